// File: rtl/vga_pkg.sv
// Shared timing constants, width helper and segment type for the VGA timing generator.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_HS_POL   = 1'b0;
  localparam bit VGA_VS_POL   = 1'b0;

  // 800x600@72, 50 MHz pixel clock, positive syncs
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 56;
  localparam int SVGA_H_SYNC   = 120;
  localparam int SVGA_H_BP     = 64;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 37;
  localparam int SVGA_V_SYNC   = 6;
  localparam int SVGA_V_BP     = 23;
  localparam bit SVGA_HS_POL   = 1'b1;
  localparam bit SVGA_VS_POL   = 1'b1;

  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FP,
    SEG_SYNC,
    SEG_BP
  } seg_e;

  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with active/sync segment decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter int W      = cnt_w(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         active,
  output logic         sync,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
  localparam logic [W-1:0] A_END = W'(ACTIVE);
  localparam logic [W-1:0] S_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] S_END = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] ONE   = W'(1);

  seg_e seg;

  always_comb begin
    seg = SEG_BP;
    unique case (1'b1)
      (cnt < A_END):                  seg = SEG_ACTIVE;
      (cnt >= A_END && cnt < S_BEG):  seg = SEG_FP;
      (cnt >= S_BEG && cnt < S_END):  seg = SEG_SYNC;
      default:                        seg = SEG_BP;
    endcase
  end

  assign active = (seg == SEG_ACTIVE);
  assign sync   = (seg == SEG_SYNC);
  assign wrap   = step && (cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI timing generator with registered, mutually aligned outputs.
// Optional colour-bar test pattern is built when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = VGA_HS_POL,
  parameter bit VS_POL   = VGA_VS_POL,
  parameter int FRAME_W  = 8,
  parameter int COLOR_W  = 1,
  localparam int H_W = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int V_W = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ce_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic [H_W-1:0]     x_o,
  output logic [V_W-1:0]     y_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      FRAME_W < 1) begin : g_bad_param
    $error("vga_timing_gen: segment parameters and FRAME_W must be >= 1");
  end

  logic [H_W-1:0]     h_cnt;
  logic [V_W-1:0]     v_cnt;
  logic               h_act, h_sync, h_wrap;
  logic               v_act, v_sync, v_wrap;
  logic [FRAME_W-1:0] frame_cnt;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (H_W)
  ) u_h (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step   (ce_i),
    .cnt    (h_cnt),
    .active (h_act),
    .sync   (h_sync),
    .wrap   (h_wrap)
  );

  // h_wrap already carries ce_i, so vertical steps once per line
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (V_W)
  ) u_v (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step   (h_wrap),
    .cnt    (v_cnt),
    .active (v_act),
    .sync   (v_sync),
    .wrap   (v_wrap)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frame_cnt <= '0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  logic de_n;
  assign de_n = h_act && v_act;

  // Strobes self-clear every clk; everything else holds when ce_i is low
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (ce_i) begin
        hsync_o       <= h_sync ? HS_POL : ~HS_POL;
        vsync_o       <= v_sync ? VS_POL : ~VS_POL;
        de_o          <= de_n;
        x_o           <= h_cnt;
        y_o           <= v_cnt;
        line_start_o  <= (h_cnt == '0);
        frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
        frame_cnt_o   <= frame_cnt;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  if (H_ACTIVE % 8 != 0) begin : g_bad_pattern
    $error("vga_timing_gen: H_ACTIVE must be a multiple of 8");
  end

  localparam logic [H_W-1:0] H_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_ACTIVE - 1);

  logic [2:0]         bar;
  logic               border;
  logic [COLOR_W-1:0] r_n, g_n, b_n;

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= H_W'(k * H_ACTIVE / 8)) bar = 3'(k);
    end
  end

  assign border = (h_cnt == '0) || (h_cnt == H_LAST) ||
                  (v_cnt == '0) || (v_cnt == V_LAST);

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (de_n && border) begin
      r_n = '1;
      g_n = '1;
      b_n = '1;
    end else if (de_n) begin
      r_n = {COLOR_W{bar[2]}};
      g_n = {COLOR_W{bar[1]}};
      b_n = {COLOR_W{bar[0]}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else if (ce_i) begin
      red_o   <= r_n;
      green_o <= g_n;
      blue_o  <= b_n;
    end
  end
`else
  assign red_o   = '0;
  assign green_o = '0;
  assign blue_o  = '0;
`endif

endmodule
